// File: rtl/nios2_cpu_cpu_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// nios2_cpu_cpu_debug_ocimem_ctrl
//
// Debug-slave side controller for the on-chip monitor RAM. Strobes from the
// debug shift chain load the address or data register and start single-word
// reads or writes on a simple waitrequest / readdatavalid RAM interface.
// Completion and failure are reported through monitor_ready / monitor_error.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   jdo[37:0]                  debug shift data (address, data, read flag)
//   take_action_ocimem_a       load address, optionally read (jdo[35])
//   take_no_action_ocimem_a    increment address, then read
//   take_action_ocimem_b       load data and write at current address
//   debugack                   CPU in debug mode; accesses refused otherwise
//   ram_address / ram_writedata / ram_read / ram_write   RAM request side
//   ram_waitrequest / ram_readdata / ram_readdatavalid   RAM response side
//   MonDReg                    data register returned to the debug slave
//   monitor_ready / monitor_error   status of the last operation
// ---------------------------------------------------------------------------
module nios2_cpu_cpu_debug_ocimem_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              debugack,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_writedata,
    output logic              ram_read,
    output logic              ram_write,
    input  logic              ram_waitrequest,
    input  logic [31:0]       ram_readdata,
    input  logic              ram_readdatavalid,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last cycle index allowed outside IDLE; an access still pending here aborts.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  mona, mona_nxt;
    logic [31:0]        mond, mond_nxt;
    logic               ready, ready_nxt;
    logic               error, error_nxt;
    logic               ovr, ovr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               strobe;
    logic               done;

    // Bits of the shift word this block never looks at.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    // Requests decode straight from state, so they cannot overlap and stay
    // put for as long as the RAM stalls.
    assign ram_read      = (state == RD_REQ);
    assign ram_write     = (state == WR_REQ);
    assign ram_address   = mona;
    assign ram_writedata = mond;
    assign MonDReg       = mond;
    assign monitor_ready = ready;
    assign monitor_error = error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mona  <= '0;
            mond  <= '0;
            ready <= 1'b1;
            error <= 1'b0;
            ovr   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            mona  <= mona_nxt;
            mond  <= mond_nxt;
            ready <= ready_nxt;
            error <= error_nxt;
            ovr   <= ovr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mona_nxt  = mona;
        mond_nxt  = mond;
        ready_nxt = ready;
        error_nxt = error;
        ovr_nxt   = ovr;
        cnt_nxt   = cnt;
        done      = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (strobe) begin
                    ovr_nxt   = 1'b0;
                    ready_nxt = 1'b0;
                    error_nxt = 1'b0;
                    if (!debugack) begin
                        // Refused: report failure, touch nothing.
                        ready_nxt = 1'b1;
                        error_nxt = 1'b1;
                    end else if (take_action_ocimem_b) begin
                        mond_nxt  = jdo[34:3];
                        state_nxt = WR_REQ;
                    end else if (take_action_ocimem_a) begin
                        mona_nxt = jdo[17+ADDR_W-1:17];
                        if (jdo[35]) state_nxt = RD_REQ;
                        else         ready_nxt = 1'b1;
                    end else begin
                        mona_nxt  = mona + ADDR_W'(1);
                        state_nxt = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (!ram_waitrequest) begin
                    // Zero-latency data arriving with the acceptance finishes here.
                    if (ram_readdatavalid) begin
                        mond_nxt = ram_readdata;
                        done     = 1'b1;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (ram_readdatavalid) begin
                    mond_nxt = ram_readdata;
                    done     = 1'b1;
                end
            end
            WR_REQ: begin
                if (!ram_waitrequest) begin
                    mona_nxt = mona + ADDR_W'(1);
                    done     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE) begin
            if (strobe) ovr_nxt = 1'b1;
            if (done) begin
                // A strobe dropped on the completing cycle still counts as overrun.
                state_nxt = IDLE;
                ready_nxt = 1'b1;
                error_nxt = ovr | strobe;
            end else if (cnt == CNT_LAST) begin
                // Abort: registers keep whatever they held before this access.
                state_nxt = IDLE;
                ready_nxt = 1'b1;
                error_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nios2_cpu_cpu_debug_ocimem_ctrl.sv
module tb_nios2_cpu_cpu_debug_ocimem_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic        debugack;
    logic [7:0]  ram_address;
    logic [31:0] ram_writedata;
    logic        ram_read, ram_write;
    logic        ram_waitrequest;
    logic [31:0] ram_readdata;
    logic        ram_readdatavalid;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int errors = 0;
    int checks = 0;

    // Reference state: address/data registers and RAM contents.
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    nios2_cpu_cpu_debug_ocimem_ctrl #(.TIMEOUT(TO), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .debugack(debugack),
        .ram_address(ram_address), .ram_writedata(ram_writedata),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_waitrequest(ram_waitrequest), .ram_readdata(ram_readdata),
        .ram_readdatavalid(ram_readdatavalid),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic rd, input logic [7:0] a);
        logic [37:0] j;
        j = {6'($urandom()), $urandom()};
        j[35] = rd;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j = {6'($urandom()), $urandom()};
        j[34:3] = d;
        return j;
    endfunction

    // One debug operation. mask = {b, a, no_action_a}. ws = stall cycles on the
    // request, lat = cycles from read acceptance to readdatavalid. inj drops a
    // stray strobe on the first busy cycle.
    task automatic run_op(input string tag, input logic [2:0] mask, input logic [37:0] j,
                          input logic dbg, input int ws, input int lat, input bit inj);
        logic [7:0]  acc_a, new_a;
        logic [31:0] new_d;
        bit          is_rd, is_wr, exp_err;
        int          exp_busy, exp_rd, exp_wr, n;
        int          busy, nrd, nwr, bad, acc;

        // Expected outcome from the operation's rules.
        is_rd = 0; is_wr = 0; exp_err = 0;
        exp_busy = 0; exp_rd = 0; exp_wr = 0;
        acc_a = exp_a; new_a = exp_a; new_d = exp_d;
        if (!dbg) exp_err = 1;
        else if (mask[2]) begin is_wr = 1; new_d = j[34:3]; end
        else if (mask[1]) begin new_a = j[24:17]; acc_a = new_a; is_rd = j[35]; end
        else begin new_a = exp_a + 8'd1; acc_a = new_a; is_rd = 1; end
        if (is_wr) begin
            n = ws + 1;
            if (n <= TO) begin exp_busy = n; exp_wr = n; new_a = acc_a + 8'd1; end
            else begin exp_busy = TO; exp_wr = TO; exp_err = 1; end
        end
        if (is_rd) begin
            n = ws + 1 + lat;
            if (n <= TO) begin exp_busy = n; exp_rd = ws + 1; new_d = mem[acc_a]; end
            else begin exp_busy = TO; exp_rd = (ws + 1 < TO) ? ws + 1 : TO; exp_err = 1; end
        end
        if (exp_busy > 0 && inj) exp_err = 1;

        // Issue the strobe; stray readdatavalid while idle must be ignored.
        @(negedge clk);
        {take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a} = mask;
        jdo = j; debugack = dbg;
        ram_readdatavalid = 1'b1; ram_readdata = $urandom();
        busy = 0; nrd = 0; nwr = 0; bad = 0; acc = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            {take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a} = 3'b000;
            ram_readdatavalid = 1'b0; ram_waitrequest = 1'b0;
            if (monitor_ready) break;
            if (ram_read && ram_write) bad++;
            if ((ram_read || ram_write) && ram_address !== acc_a) bad++;
            if (ram_read) nrd++;
            if (ram_write) nwr++;
            if (ram_read || ram_write) begin
                if (busy < ws) ram_waitrequest = 1'b1;
                else if (acc < 0) acc = busy;
            end
            if (is_rd && acc >= 0 && busy == acc + lat) begin
                ram_readdatavalid = 1'b1;
                ram_readdata = mem[ram_address];
            end
            if (inj && busy == 0) take_no_action_ocimem_a = 1'b1;
            busy++;
        end

        chk({tag, "/busy"},  64'(busy), 64'(exp_busy));
        chk({tag, "/ready"}, 64'(monitor_ready), 64'd1);
        chk({tag, "/error"}, 64'(monitor_error), 64'(exp_err));
        chk({tag, "/mond"},  64'(MonDReg), 64'(new_d));
        chk({tag, "/addr"},  64'(ram_address), 64'(new_a));
        chk({tag, "/nrd"},   64'(nrd), 64'(exp_rd));
        chk({tag, "/nwr"},   64'(nwr), 64'(exp_wr));
        chk({tag, "/bus"},   64'(bad), 64'd0);
        exp_a = new_a;
        exp_d = new_d;
    endtask

    initial begin
        int nreq;
        reset = 1'b1; jdo = '0; debugack = 1'b1;
        take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
        ram_waitrequest = 0; ram_readdata = '0; ram_readdatavalid = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[8'h10] = 32'hDEADBEEF;
        exp_a = '0; exp_d = '0;

        repeat (3) @(negedge clk);
        chk("rst/ready", 64'(monitor_ready), 64'd1);
        chk("rst/error", 64'(monitor_error), 64'd0);
        chk("rst/rw",    64'({ram_read, ram_write}), 64'd0);
        chk("rst/addr",  64'(ram_address), 64'd0);
        chk("rst/mond",  64'(MonDReg), 64'd0);
        reset = 1'b0;

        // Directed cases.
        run_op("rd10",  3'b010, mk_a(1'b1, 8'h10), 1'b1, 0, 2, 0);
        run_op("setff", 3'b010, mk_a(1'b0, 8'hFF), 1'b1, 0, 0, 0);
        run_op("wrff",  3'b100, mk_b(32'h12345678), 1'b1, 3, 0, 0);
        run_op("set05", 3'b010, mk_a(1'b0, 8'h05), 1'b1, 0, 0, 0);
        run_op("inc06", 3'b001, mk_a(1'b0, 8'h00), 1'b1, 1, 0, 0);
        run_op("rdto",  3'b010, mk_a(1'b1, 8'h33), 1'b1, 0, 99, 0);
        run_op("wrto",  3'b100, mk_b(32'hA5A5A5A5), 1'b1, 20, 0, 0);
        run_op("nodbg", 3'b111, mk_b(32'h0BADF00D), 1'b0, 0, 0, 0);
        run_op("all3",  3'b111, mk_b(32'h87654321), 1'b1, 0, 0, 0);
        run_op("ovr",   3'b001, mk_a(1'b0, 8'h00), 1'b1, 2, 2, 1);
        run_op("clr",   3'b010, mk_a(1'b1, 8'h40), 1'b1, 0, 0, 0);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] m;
            int ws, lat;
            m   = 3'($urandom_range(1, 7));
            ws  = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            lat = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 20) : $urandom_range(0, 3);
            run_op($sformatf("rnd%0d", i), m, {6'($urandom()), $urandom()},
                   1'($urandom_range(0, 9) != 0), ws, lat, $urandom_range(0, 4) == 0);
        end

        // Reset in the middle of a read wait; late data must be ignored.
        @(negedge clk);
        take_action_ocimem_a = 1'b1; jdo = mk_a(1'b1, 8'h20); debugack = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst/rw",    64'({ram_read, ram_write}), 64'd0);
        chk("mrst/ready", 64'(monitor_ready), 64'd1);
        chk("mrst/error", 64'(monitor_error), 64'd0);
        chk("mrst/mond",  64'(MonDReg), 64'd0);
        chk("mrst/addr",  64'(ram_address), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ram_readdatavalid = 1'b1; ram_readdata = 32'hCAFEF00D;
        nreq = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            ram_readdatavalid = 1'b0;
            if (ram_read || ram_write) nreq++;
        end
        chk("mrst/nreq",   64'(nreq), 64'd0);
        chk("mrst/late",   64'(MonDReg), 64'd0);
        chk("mrst/ready2", 64'(monitor_ready), 64'd1);
        exp_a = '0; exp_d = '0;

        run_op("post", 3'b001, mk_a(1'b0, 8'h00), 1'b1, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios2_cpu_cpu_debug_ocimem_ctrl.md
NIOS2_CPU_CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: nios2_cpu_cpu_debug_ocimem_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, the maximum number of cycles spent in RD_REQ, RD_WAIT or WR_REQ before an access is aborted.
REQ-002 The block SHALL have parameter ADDR_W, default 8, the width of the monitor word address.
REQ-003 Ports SHALL be as follows; one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- jdo  in  38  debug-slave shift data, sysclk domain.
- take_action_ocimem_a  in  1  one-cycle strobe: load address, optional read.
- take_no_action_ocimem_a  in  1  one-cycle strobe: increment address, then read.
- take_action_ocimem_b  in  1  one-cycle strobe: write data.
- debugack  in  1  CPU is in debug mode.
- ram_address  out  ADDR_W  monitor RAM word address.
- ram_writedata  out  32  write data.
- ram_read  out  1  read request.
- ram_write  out  1  write request.
- ram_waitrequest  in  1  request stall.
- ram_readdata  in  32  read data.
- ram_readdatavalid  in  1  read data valid.
- MonDReg  out  32  monitor data register, returned to the debug slave.
- monitor_ready  out  1  last operation complete.
- monitor_error  out  1  last operation failed.

Function
REQ-004 The FSM SHALL have four states: IDLE, RD_REQ, RD_WAIT and WR_REQ.
REQ-005 Strobes SHALL be accepted only in IDLE; if more than one strobe is asserted in the same cycle, priority SHALL be take_action_ocimem_b, then take_action_ocimem_a, then take_no_action_ocimem_a.
REQ-006 On an accepted strobe, monitor_ready and monitor_error SHALL clear in the following cycle.
REQ-007 take_action_ocimem_a SHALL load MonAReg with jdo[17+ADDR_W-1:17]; if jdo[35]=1 the FSM SHALL go to RD_REQ, otherwise it SHALL stay in IDLE and set monitor_ready=1 in the next cycle.
REQ-008 take_no_action_ocimem_a SHALL set MonAReg to MonAReg+1, wrapping from all-ones to 0, and go to RD_REQ; the read SHALL use the incremented address.
REQ-009 take_action_ocimem_b SHALL load MonDReg with jdo[34:3] and go to WR_REQ at the current MonAReg.
REQ-010 ram_address SHALL always equal MonAReg, and ram_writedata SHALL always equal MonDReg.
REQ-011 In RD_REQ, ram_read SHALL be 1; on the first cycle with ram_waitrequest=0 the FSM SHALL go to RD_WAIT.
REQ-012 In RD_WAIT, on ram_readdatavalid=1 MonDReg SHALL load ram_readdata, monitor_ready SHALL be set to 1, and the FSM SHALL return to IDLE.
REQ-013 ram_readdatavalid in the same cycle as RD_REQ acceptance SHALL be honoured; readdatavalid outside RD_REQ/RD_WAIT SHALL be ignored.
REQ-014 In WR_REQ, ram_write SHALL be 1; on ram_waitrequest=0 MonAReg SHALL increment (with wrap), monitor_ready SHALL be set to 1, and the FSM SHALL return to IDLE.
REQ-015 ram_read and ram_write SHALL never be asserted together, and SHALL be held stable while ram_waitrequest=1.
REQ-016 A timeout counter SHALL clear on leaving IDLE and count every cycle outside IDLE; when it reaches TIMEOUT the block SHALL abort to IDLE with monitor_error=1 and monitor_ready=1, leaving MonDReg and MonAReg unchanged.
REQ-017 An accepted strobe while debugack=0 SHALL cause no RAM access and no register change, and SHALL set monitor_error=1 and monitor_ready=1 in the next cycle.
REQ-018 A strobe arriving outside IDLE SHALL be dropped and SHALL set a sticky overrun flag; that flag SHALL be ORed into monitor_error at completion and cleared on the next accepted strobe.
REQ-019 monitor_ready and monitor_error SHALL hold until the next accepted strobe.

Reset
REQ-020 While reset=1: state=IDLE, MonAReg=0, MonDReg=0, ram_read=0, ram_write=0, monitor_ready=1, monitor_error=0, timeout counter=0, overrun flag=0.
REQ-021 Reset asserted mid-access SHALL abort immediately, with no further request cycle after reset deassertion.

Verification
REQ-022 take_action_ocimem_a with jdo[24:17]=0x10, jdo[35]=1, debugack=1; RAM returns 0xDEADBEEF after 2 cycles -> ram_address=0x10, MonDReg=0xDEADBEEF, monitor_ready=1, monitor_error=0.
REQ-023 MonAReg=0xFF, take_action_ocimem_b with jdo[34:3]=0x12345678, ram_waitrequest=1 for 3 cycles -> ram_write held 4 cycles at address 0xFF, then MonAReg=0x00 and monitor_ready=1.
REQ-024 MonAReg=0x05, take_no_action_ocimem_a -> read at 0x06.
REQ-025 Read request accepted but readdatavalid never asserted -> abort after 15 cycles with monitor_error=1 and MonDReg unchanged.
REQ-026 Strobe with debugack=0 -> no ram_read or ram_write and monitor_error=1; all three strobes in one cycle -> only the write executes.
REQ-027 reset pulsed during RD_WAIT -> all outputs return to reset values, and a subsequent late readdatavalid has no effect.
